// File: rtl/sd_pkg.sv
// sd_pkg: shared encodings for the SD card-clock generator.
//   - freq_sel encodings (FREQ_LOW / FREQ_HIGH / FREQ_CUSTOM; 3 behaves as low)
//   - default divider values (half-period = divider + 1 clk cycles)
//   - two-state FSM encoding for sd_clk_gen
package sd_pkg;

    localparam logic [1:0] FREQ_LOW    = 2'd0;
    localparam logic [1:0] FREQ_HIGH   = 2'd1;
    localparam logic [1:0] FREQ_CUSTOM = 2'd2;

    localparam int DEF_DIV_WIDTH        = 8;
    localparam int DEF_LOWFREQ_DIVIDER  = 124; // 400 kHz from 100 MHz
    localparam int DEF_HIGHFREQ_DIVIDER = 1;   // 25 MHz from 100 MHz

    typedef enum logic {
        STOPPED = 1'b0,
        RUN     = 1'b1
    } clk_state_t;

endpackage

// File: rtl/sd_clk_gen.sv
// sd_clk_gen: runtime-switchable, glitch-free SD/SDIO card-clock generator.
//
// Ports:
//   clk            system clock (sole domain)
//   reset          synchronous active-high reset
//   clk_en         1 = card clock may run; 0 = park low after current low phase
//   stop_req       flow-control pause, same semantics as clk_en = 0
//   freq_sel       0 low, 1 high, 2 custom_div, 3 low
//   custom_div     runtime divider for freq_sel = 2
//   sdio_clk       registered card clock
//   rise_stb       pulse in first clk cycle sdio_clk is 1
//   fall_stb       pulse in first clk cycle sdio_clk is 0
//   clk_stopped    1 while parked low
//   switch_pending selected divider differs from the active one (combinational)
//
// Every half-period lasts div_active + 1 clk cycles. The divider is latched
// only on a rising edge, so a period is always built from one divider value.
module sd_clk_gen
    import sd_pkg::*;
#(
    parameter int DIV_WIDTH        = DEF_DIV_WIDTH,
    parameter int LOWFREQ_DIVIDER  = DEF_LOWFREQ_DIVIDER,
    parameter int HIGHFREQ_DIVIDER = DEF_HIGHFREQ_DIVIDER
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    input  logic                 stop_req,
    input  logic [1:0]           freq_sel,
    input  logic [DIV_WIDTH-1:0] custom_div,
    output logic                 sdio_clk,
    output logic                 rise_stb,
    output logic                 fall_stb,
    output logic                 clk_stopped,
    output logic                 switch_pending
);

    localparam logic [DIV_WIDTH-1:0] LOW_DIV  = DIV_WIDTH'(LOWFREQ_DIVIDER);
    localparam logic [DIV_WIDTH-1:0] HIGH_DIV = DIV_WIDTH'(HIGHFREQ_DIVIDER);

    clk_state_t           state, state_nx;
    logic [DIV_WIDTH-1:0] cnt, cnt_nx;
    logic [DIV_WIDTH-1:0] div_active, div_nx;
    logic [DIV_WIDTH-1:0] sel_div;
    logic                 sdio_nx, rise_nx, fall_nx, stopped_nx;
    logic                 go;

    always_comb begin
        case (freq_sel)
            FREQ_HIGH:   sel_div = HIGH_DIV;
            FREQ_CUSTOM: sel_div = custom_div;
            FREQ_LOW:    sel_div = LOW_DIV;
            default:     sel_div = LOW_DIV;
        endcase
    end

    assign switch_pending = (sel_div != div_active);
    assign go             = clk_en && !stop_req;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        div_nx     = div_active;
        sdio_nx    = sdio_clk;
        rise_nx    = 1'b0;
        fall_nx    = 1'b0;
        stopped_nx = clk_stopped;
        case (state)
            STOPPED: begin
                sdio_nx    = 1'b0;
                stopped_nx = 1'b1;
                // Resume edge picks up whatever divider is selected right now.
                if (go) begin
                    state_nx   = RUN;
                    sdio_nx    = 1'b1;
                    rise_nx    = 1'b1;
                    stopped_nx = 1'b0;
                    div_nx     = sel_div;
                    cnt_nx     = sel_div;
                end
            end
            RUN: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (sdio_clk) begin
                    // Low phase reuses the divider latched at the rise.
                    sdio_nx = 1'b0;
                    fall_nx = 1'b1;
                    cnt_nx  = div_active;
                end else if (go) begin
                    // Only point where a new divider takes effect.
                    sdio_nx = 1'b1;
                    rise_nx = 1'b1;
                    div_nx  = sel_div;
                    cnt_nx  = sel_div;
                end else begin
                    // Full low phase already done; park low.
                    state_nx   = STOPPED;
                    stopped_nx = 1'b1;
                    sdio_nx    = 1'b0;
                end
            end
            default: begin
                state_nx   = STOPPED;
                sdio_nx    = 1'b0;
                stopped_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= STOPPED;
            cnt         <= '0;
            div_active  <= LOW_DIV;
            sdio_clk    <= 1'b0;
            rise_stb    <= 1'b0;
            fall_stb    <= 1'b0;
            clk_stopped <= 1'b1;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            div_active  <= div_nx;
            sdio_clk    <= sdio_nx;
            rise_stb    <= rise_nx;
            fall_stb    <= fall_nx;
            clk_stopped <= stopped_nx;
        end
    end

endmodule

// File: tb/tb_sd_clk_gen.sv
// tb_sd_clk_gen: directed bench for sd_clk_gen with default parameters.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_sd_clk_gen;

    logic       clk;
    logic       reset;
    logic       clk_en;
    logic       stop_req;
    logic [1:0] freq_sel;
    logic [7:0] custom_div;
    logic       sdio_clk, rise_stb, fall_stb, clk_stopped, switch_pending;

    int n_cmp  = 0;
    int n_fail = 0;

    sd_clk_gen dut (
        .clk            (clk),
        .reset          (reset),
        .clk_en         (clk_en),
        .stop_req       (stop_req),
        .freq_sel       (freq_sel),
        .custom_div     (custom_div),
        .sdio_clk       (sdio_clk),
        .rise_stb       (rise_stb),
        .fall_stb       (fall_stb),
        .clk_stopped    (clk_stopped),
        .switch_pending (switch_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Length of the current phase at level lvl, starting at the current
    // sample. stb counts the strobe belonging to this level; a strobe of
    // the opposite kind inside the phase is a failure.
    task automatic run_len(input logic lvl, output int n, output int stb);
        n = 0;
        stb = 0;
        while (sdio_clk === lvl && n < 1000) begin
            n++;
            if ((lvl ? rise_stb : fall_stb) === 1'b1) stb++;
            n_cmp++;
            if ((lvl ? fall_stb : rise_stb) !== 1'b0) begin
                n_fail++;
                $display("FAIL wrong_strobe: lvl=%0b rise=%0b fall=%0b", lvl, rise_stb, fall_stb);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clk_en = 1'b0; stop_req = 1'b0; freq_sel = 2'd0; custom_div = 8'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if (sdio_clk !== 1'b0) begin n_fail++; $display("FAIL reset_sdio: got %0b want 0", sdio_clk); end
        n_cmp++; if (rise_stb !== 1'b0 || fall_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %0b%0b want 00", rise_stb, fall_stb); end
        n_cmp++; if (clk_stopped !== 1'b1) begin n_fail++; $display("FAIL reset_stopped: got %0b want 1", clk_stopped); end
        n_cmp++; if (switch_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending_low: got %0b want 0", switch_pending); end
        freq_sel = 2'd1; #1;
        n_cmp++; if (switch_pending !== 1'b1) begin n_fail++; $display("FAIL reset_pending_high: got %0b want 1", switch_pending); end
        freq_sel = 2'd3; #1;
        n_cmp++; if (switch_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending_sel3: got %0b want 0", switch_pending); end
        freq_sel = 2'd0;
    endtask

    task automatic test_low_default();
        int n, s;
        @(negedge clk);
        reset = 1'b0; clk_en = 1'b1;
        @(negedge clk);
        n_cmp++; if (sdio_clk !== 1'b1 || rise_stb !== 1'b1 || clk_stopped !== 1'b0) begin
            n_fail++; $display("FAIL low_first_rise: clk=%0b rise=%0b stopped=%0b want 1 1 0", sdio_clk, rise_stb, clk_stopped); end
        run_len(1'b1, n, s);
        n_cmp++; if (n !== 125 || s !== 1) begin n_fail++; $display("FAIL low_high_len: len=%0d stb=%0d want 125 1", n, s); end
        run_len(1'b0, n, s);
        n_cmp++; if (n !== 125 || s !== 1) begin n_fail++; $display("FAIL low_low_len: len=%0d stb=%0d want 125 1", n, s); end
    endtask

    task automatic test_switch_high();
        int n, s;
        repeat (10) @(negedge clk);
        freq_sel = 2'd1; #1;
        n_cmp++; if (switch_pending !== 1'b1) begin n_fail++; $display("FAIL sw_pending_set: got %0b want 1", switch_pending); end
        run_len(1'b1, n, s);
        n_cmp++; if (n !== 115 || s !== 0) begin n_fail++; $display("FAIL sw_rest_high: len=%0d stb=%0d want 115 0", n, s); end
        n_cmp++; if (switch_pending !== 1'b1) begin n_fail++; $display("FAIL sw_pending_low: got %0b want 1", switch_pending); end
        run_len(1'b0, n, s);
        n_cmp++; if (n !== 125 || s !== 1) begin n_fail++; $display("FAIL sw_old_low: len=%0d stb=%0d want 125 1", n, s); end
        n_cmp++; if (switch_pending !== 1'b0) begin n_fail++; $display("FAIL sw_pending_clear: got %0b want 0", switch_pending); end
        run_len(1'b1, n, s);
        n_cmp++; if (n !== 2 || s !== 1) begin n_fail++; $display("FAIL sw_new_high: len=%0d stb=%0d want 2 1", n, s); end
        run_len(1'b0, n, s);
        n_cmp++; if (n !== 2 || s !== 1) begin n_fail++; $display("FAIL sw_new_low: len=%0d stb=%0d want 2 1", n, s); end
    endtask

    task automatic test_custom();
        int n, s;
        freq_sel = 2'd2; custom_div = 8'd0;
        run_len(1'b1, n, s);
        n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL cust_prev_high: len=%0d want 2", n); end
        run_len(1'b0, n, s);
        n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL cust_prev_low: len=%0d want 2", n); end
        run_len(1'b1, n, s);
        n_cmp++; if (n !== 1 || s !== 1) begin n_fail++; $display("FAIL cust0_high: len=%0d stb=%0d want 1 1", n, s); end
        run_len(1'b0, n, s);
        n_cmp++; if (n !== 1 || s !== 1) begin n_fail++; $display("FAIL cust0_low: len=%0d stb=%0d want 1 1", n, s); end
        run_len(1'b1, n, s);
        n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL cust0_high2: len=%0d want 1", n); end
        custom_div = 8'd9;
        run_len(1'b0, n, s);
        n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL cust_mid_low: len=%0d want 1", n); end
        run_len(1'b1, n, s);
        n_cmp++; if (n !== 10 || s !== 1) begin n_fail++; $display("FAIL cust9_high: len=%0d stb=%0d want 10 1", n, s); end
        run_len(1'b0, n, s);
        n_cmp++; if (n !== 10 || s !== 1) begin n_fail++; $display("FAIL cust9_low: len=%0d stb=%0d want 10 1", n, s); end
    endtask

    task automatic test_stop();
        int n, s;
        freq_sel = 2'd1;
        run_len(1'b1, n, s);
        run_len(1'b0, n, s);
        @(negedge clk);
        stop_req = 1'b1;
        run_len(1'b1, n, s);
        n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL stop_high_rest: len=%0d want 1", n); end
        n_cmp++; if (fall_stb !== 1'b1 || clk_stopped !== 1'b0) begin n_fail++; $display("FAIL stop_l1: fall=%0b stopped=%0b want 1 0", fall_stb, clk_stopped); end
        @(negedge clk);
        n_cmp++; if (sdio_clk !== 1'b0 || clk_stopped !== 1'b0) begin n_fail++; $display("FAIL stop_l2: clk=%0b stopped=%0b want 0 0", sdio_clk, clk_stopped); end
        @(negedge clk);
        n_cmp++; if (sdio_clk !== 1'b0 || clk_stopped !== 1'b1 || rise_stb !== 1'b0) begin
            n_fail++; $display("FAIL stop_parked: clk=%0b stopped=%0b rise=%0b want 0 1 0", sdio_clk, clk_stopped, rise_stb); end
        repeat (4) @(negedge clk);
        n_cmp++; if (sdio_clk !== 1'b0 || clk_stopped !== 1'b1) begin n_fail++; $display("FAIL stop_hold: clk=%0b stopped=%0b want 0 1", sdio_clk, clk_stopped); end
        stop_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (sdio_clk !== 1'b1 || rise_stb !== 1'b1 || clk_stopped !== 1'b0) begin
            n_fail++; $display("FAIL stop_resume: clk=%0b rise=%0b stopped=%0b want 1 1 0", sdio_clk, rise_stb, clk_stopped); end
        run_len(1'b1, n, s);
        n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL stop_resume_high: len=%0d want 2", n); end
        run_len(1'b0, n, s);
        n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL stop_resume_low: len=%0d want 2", n); end
    endtask

    task automatic test_stop_cancel();
        int n, s;
        stop_req = 1'b1;
        run_len(1'b1, n, s);
        stop_req = 1'b0;
        run_len(1'b0, n, s);
        n_cmp++; if (n !== 2) begin n_fail++; $display("FAIL cancel_low: len=%0d want 2", n); end
        n_cmp++; if (sdio_clk !== 1'b1 || rise_stb !== 1'b1 || clk_stopped !== 1'b0) begin
            n_fail++; $display("FAIL cancel_rise: clk=%0b rise=%0b stopped=%0b want 1 1 0", sdio_clk, rise_stb, clk_stopped); end
    endtask

    task automatic test_resume_new_div();
        int n, s, edges;
        clk_en = 1'b0;
        run_len(1'b1, n, s);
        repeat (2) @(negedge clk);
        n_cmp++; if (sdio_clk !== 1'b0 || clk_stopped !== 1'b1) begin n_fail++; $display("FAIL en_parked: clk=%0b stopped=%0b want 0 1", sdio_clk, clk_stopped); end
        freq_sel = 2'd2; custom_div = 8'd5; #1;
        n_cmp++; if (switch_pending !== 1'b1) begin n_fail++; $display("FAIL en_pending: got %0b want 1", switch_pending); end
        edges = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sdio_clk !== 1'b0 || rise_stb !== 1'b0 || fall_stb !== 1'b0) edges++;
        end
        n_cmp++; if (edges !== 0) begin n_fail++; $display("FAIL en_no_edges: got %0d want 0", edges); end
        custom_div = 8'd3; clk_en = 1'b1;
        @(negedge clk);
        n_cmp++; if (sdio_clk !== 1'b1 || rise_stb !== 1'b1) begin n_fail++; $display("FAIL en_resume: clk=%0b rise=%0b want 1 1", sdio_clk, rise_stb); end
        run_len(1'b1, n, s);
        n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL en_new_high: len=%0d want 4", n); end
        run_len(1'b0, n, s);
        n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL en_new_low: len=%0d want 4", n); end
    endtask

    task automatic test_reset_mid_high();
        int n, s;
        @(negedge clk);
        n_cmp++; if (sdio_clk !== 1'b1) begin n_fail++; $display("FAIL rst_pre_high: got %0b want 1", sdio_clk); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (sdio_clk !== 1'b0 || clk_stopped !== 1'b1 || rise_stb !== 1'b0 || fall_stb !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: clk=%0b stopped=%0b rise=%0b fall=%0b want 0 1 0 0", sdio_clk, clk_stopped, rise_stb, fall_stb); end
        freq_sel = 2'd0; #1;
        n_cmp++; if (switch_pending !== 1'b0) begin n_fail++; $display("FAIL rst_div_low: pending=%0b want 0", switch_pending); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (sdio_clk !== 1'b1 || rise_stb !== 1'b1) begin n_fail++; $display("FAIL rst_restart: clk=%0b rise=%0b want 1 1", sdio_clk, rise_stb); end
        run_len(1'b1, n, s);
        n_cmp++; if (n !== 125) begin n_fail++; $display("FAIL rst_restart_high: len=%0d want 125", n); end
    endtask

    initial begin
        test_reset();
        test_low_default();
        test_switch_high();
        test_custom();
        test_stop();
        test_stop_cancel();
        test_resume_new_div();
        test_reset_mid_high();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
